// File: rtl/ahb_sram_ws_slave_if.sv
// AHB-Lite bus bundle between the interconnect and one SRAM slave.
// HREADY is the bus-wide ready returned by the interconnect; HREADYOUT is this slave's own ready.
interface ahb_sram_ws_slave_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
);
  logic                  HSEL;
  logic [ADDR_WIDTH-1:0] HADDR;
  logic [1:0]            HTRANS;
  logic                  HWRITE;
  logic [2:0]            HSIZE;
  logic [DATA_WIDTH-1:0] HWDATA;
  logic                  HREADY;
  logic                  HREADYOUT;
  logic [1:0]            HRESP;
  logic [DATA_WIDTH-1:0] HRDATA;

  modport master (
    output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    input  HREADYOUT, HRESP, HRDATA
  );

  modport slave (
    input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
    output HREADYOUT, HRESP, HRDATA
  );
endinterface

// File: rtl/ahb_sram_ws_slave.sv
// AHB-Lite SRAM slave with configurable width, depth and wait states.
// The address phase is latched on accept; HWDATA is consumed in the data phase.
// Byte-lane writes commit on the edge that ends DATA. A read entering DATA on that
// same edge sees the committing write's bytes through a forwarding merge.
module ahb_sram_ws_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_BYTES   = 8192,
  parameter int WAIT_STATES = 0
) (
  input logic                HCLK,
  input logic                HRESETn,
  ahb_sram_ws_slave_if.slave bus
);
  localparam int BYTES  = DATA_WIDTH / 8;
  localparam int OFF_W  = $clog2(BYTES);
  localparam int MEM_AW = $clog2(MEM_BYTES);
  localparam int IDX_W  = (MEM_AW > OFF_W) ? (MEM_AW - OFF_W) : 1;
  localparam int DEPTH  = MEM_BYTES / BYTES;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_DATA = 3'd2,
    ST_ERR1 = 3'd3,
    ST_ERR2 = 3'd4
  } state_t;

  // Byte-lane enables for a transfer of 2^size bytes starting at lane off.
  function automatic logic [BYTES-1:0] lane_mask(input logic [2:0] size, input logic [2:0] off);
    logic [15:0] base;
    logic [15:0] shifted;
    case (size)
      3'd0:    base = 16'h0001;
      3'd1:    base = 16'h0003;
      3'd2:    base = 16'h000F;
      3'd3:    base = 16'h00FF;
      default: base = 16'h0000;
    endcase
    shifted = base << off;
    return shifted[BYTES-1:0];
  endfunction

  // Overlay the enabled bytes of new_word on old_word.
  function automatic logic [DATA_WIDTH-1:0] merge_lanes(input logic [DATA_WIDTH-1:0] old_word,
                                                        input logic [DATA_WIDTH-1:0] new_word,
                                                        input logic [BYTES-1:0]      mask);
    logic [DATA_WIDTH-1:0] res;
    res = old_word;
    for (int b = 0; b < BYTES; b++) begin
      if (mask[b]) res[8*b +: 8] = new_word[8*b +: 8];
    end
    return res;
  endfunction

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];

  state_t                state_r;
  state_t                state_s;
  logic [IDX_W-1:0]      idx_r;
  logic [BYTES-1:0]      mask_r;
  logic                  write_r;
  logic [3:0]            cnt_r;
  logic                  hreadyout_r;
  logic [1:0]            hresp_r;
  logic [DATA_WIDTH-1:0] hrdata_r;

  logic                  accept_s;
  logic                  load_s;
  logic                  err_s;
  logic                  range_err_s;
  logic                  size_err_s;
  logic                  align_err_s;
  logic [7:0]            align_mask_s;
  logic [IDX_W-1:0]      new_idx_s;
  logic [BYTES-1:0]      new_mask_s;
  logic                  commit_s;
  logic [IDX_W-1:0]      rd_idx_s;
  logic                  rd_en_s;
  logic [DATA_WIDTH-1:0] rd_word_s;
  logic                  ready_s;
  logic [1:0]            resp_s;
  logic                  unused_s;

  // HTRANS[0] only separates IDLE/BUSY and NONSEQ/SEQ, which are treated alike.
  assign unused_s = bus.HTRANS[0];

  // Only accept while this slave is ready, so a stalled address phase is never latched.
  assign accept_s     = bus.HSEL & bus.HREADY & bus.HTRANS[1] & hreadyout_r;
  assign range_err_s  = (bus.HADDR >> MEM_AW) != '0;
  assign size_err_s   = bus.HSIZE > 3'(OFF_W);
  assign align_mask_s = 8'((9'd1 << bus.HSIZE) - 9'd1);
  assign align_err_s  = |({5'd0, bus.HADDR[2:0]} & align_mask_s);
  assign err_s        = range_err_s | size_err_s | align_err_s;
  assign new_idx_s    = IDX_W'(bus.HADDR >> OFF_W);
  assign new_mask_s   = lane_mask(bus.HSIZE, 3'(bus.HADDR[OFF_W-1:0]));
  assign commit_s     = (state_r == ST_DATA) & write_r;

  // Next-state decode and the ready/response values that go with the next state.
  always_comb begin
    state_s = state_r;
    load_s  = 1'b0;
    case (state_r)
      ST_IDLE, ST_DATA, ST_ERR2: begin
        if (accept_s) begin
          if (err_s) begin
            state_s = ST_ERR1;
          end else begin
            load_s  = 1'b1;
            state_s = (WAIT_STATES != 0) ? ST_WAIT : ST_DATA;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r == 4'd0) state_s = ST_DATA;
        else               state_s = ST_WAIT;
      end
      ST_ERR1: state_s = ST_ERR2;
      default: state_s = ST_IDLE;
    endcase
    ready_s = (state_s != ST_WAIT) && (state_s != ST_ERR1);
    resp_s  = ((state_s == ST_ERR1) || (state_s == ST_ERR2)) ? 2'b01 : 2'b00;
  end

  // Read data for the transfer entering DATA, with forwarding from a write committing now.
  always_comb begin
    rd_idx_s  = load_s ? new_idx_s : idx_r;
    rd_en_s   = (state_s == ST_DATA) && !(load_s ? bus.HWRITE : write_r);
    rd_word_s = mem_r[rd_idx_s];
    if (commit_s && (idx_r == rd_idx_s)) begin
      rd_word_s = merge_lanes(mem_r[rd_idx_s], bus.HWDATA, mask_r);
    end else begin
      rd_word_s = mem_r[rd_idx_s];
    end
  end

  // FSM state and registered bus outputs.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_r     <= ST_IDLE;
      hreadyout_r <= 1'b1;
      hresp_r     <= 2'b00;
      hrdata_r    <= '0;
    end else begin
      state_r     <= state_s;
      hreadyout_r <= ready_s;
      hresp_r     <= resp_s;
      if (rd_en_s) hrdata_r <= rd_word_s;
    end
  end

  // Latched address-phase attributes and the wait-state down-counter.
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      idx_r   <= '0;
      mask_r  <= '0;
      write_r <= 1'b0;
      cnt_r   <= 4'd0;
    end else begin
      if (load_s) begin
        idx_r   <= new_idx_s;
        mask_r  <= new_mask_s;
        write_r <= bus.HWRITE;
        cnt_r   <= 4'(WAIT_STATES - 1);
      end else if ((state_r == ST_WAIT) && (cnt_r != 4'd0)) begin
        cnt_r <= cnt_r - 4'd1;
      end
    end
  end

  // Storage array: not reset, written lane by lane when a write data phase completes.
  always_ff @(posedge HCLK) begin
    if (commit_s) begin
      for (int b = 0; b < BYTES; b++) begin
        if (mask_r[b]) mem_r[idx_r][8*b +: 8] <= bus.HWDATA[8*b +: 8];
      end
    end
  end

  assign bus.HREADYOUT = hreadyout_r;
  assign bus.HRESP     = hresp_r;
  assign bus.HRDATA    = hrdata_r;
endmodule
